// File: rtl/int_to_float.sv
// int_to_float: multi-cycle 32-bit integer (signed or unsigned) to IEEE-754
// single-precision converter with round-to-nearest-even and a one-hot class
// code. One conversion in flight, valid/ready on both sides.
// Optional build macro INT_TO_FLOAT_FAST_NORM_EN: normalisation skips eight
// leading zeros per cycle while the top byte is clear. Results are identical
// either way; only the latency changes.
module int_to_float #(
  parameter int BIAS  = 127,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float,
  output logic [4:0]       out_type
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Exponent of a value whose leading one sits in bit 31 before normalising.
  localparam logic [8:0] EXP_INIT    = 9'(BIAS + INT_W - 1);
  localparam logic [4:0] TYPE_ZERO   = 5'b00001;
  localparam logic [4:0] TYPE_NORMAL = 5'b00010;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [8:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] out_float_q, out_float_d;
  logic [4:0]  out_type_q, out_type_d;

  logic        acc_sign;
  logic [31:0] acc_mag;
  logic [23:0] rnd;
  logic [7:0]  exp_r;

  // Round-to-nearest-even on a normalised magnitude whose implicit one has
  // already been dropped. Bit 23 of the result is the mantissa carry-out.
  function automatic logic [23:0] round_rne(input logic [30:0] m);
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        up;
    mant   = m[30:8];
    guard  = m[7];
    sticky = |m[6:0];
    up     = guard & (sticky | mant[0]);
    return {1'b0, mant} + {23'd0, up};
  endfunction

  // Operand capture: sign and magnitude of the incoming integer. The most
  // negative signed value negates to itself, which is the correct magnitude.
  assign acc_sign = in_signed & in_data[31];
  assign acc_mag  = acc_sign ? (~in_data + 32'd1) : in_data;

  // Rounding of the normalised magnitude; a carry-out bumps the exponent.
  assign rnd   = round_rne(mag_q[30:0]);
  assign exp_r = exp_q[7:0] + {7'd0, rnd[23]};

  // Next-state logic for the converter FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_float_d = out_float_q;
    out_type_d  = out_type_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = acc_sign;
          mag_d  = acc_mag;
          exp_d  = EXP_INIT;
          if (acc_mag == 32'd0) begin
            sign_d      = 1'b0;
            out_float_d = 32'd0;
            out_type_d  = TYPE_ZERO;
            state_d     = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end
`ifdef INT_TO_FLOAT_FAST_NORM_EN
        else if (mag_q[31:24] == 8'd0) begin
          mag_d = mag_q << 8;
          exp_d = exp_q - 9'd8;
        end
`endif
        else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end
      S_ROUND: begin
        out_float_d = {sign_q, exp_r, rnd[22:0]};
        out_type_d  = TYPE_NORMAL;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mag_q       <= 32'd0;
      exp_q       <= 9'd0;
      sign_q      <= 1'b0;
      out_float_q <= 32'd0;
      out_type_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_float_q <= out_float_d;
      out_type_q  <= out_type_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_float = out_float_q;
  assign out_type  = out_type_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed cases with known results,
// backpressure, asynchronous reset mid-conversion, and random operands
// compared against an arithmetic reference model.
// Latency is counted in clock edges after the accept edge until out_valid
// is seen high; a zero operand is already valid in the cycle right after
// the accept edge.
module tb_int_to_float;

`ifdef INT_TO_FLOAT_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic [4:0]  out_type;

  int total = 0;
  int bad   = 0;

  int_to_float dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .out_type  (out_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude, position of the leading one, then keep 24
  // significant bits and round the discarded remainder to nearest-even.
  function automatic void ref_conv(input logic [31:0] d, input logic s,
                                   output logic [31:0] f, output logic [4:0] t,
                                   output int lat);
    logic            neg;
    longint unsigned m, q, rem, half;
    int              p, e, sh, lz;
    logic [7:0]      e8;
    neg = s && d[31];
    m   = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (m == 0) begin
      f   = 32'd0;
      t   = 5'b00001;
      lat = 0;
      return;
    end
    p = 31;
    while (m < (64'd1 << p)) p--;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    e8  = 8'(e);
    f   = {neg, e8, q[22:0]};
    t   = 5'b00010;
    lz  = 31 - p;
    lat = FAST ? (lz / 8 + lz % 8 + 2) : (lz + 2);
  endfunction

  // Present one operand in IDLE, wait (bounded) for the result.
  task automatic conv(input logic [31:0] d, input logic s,
                      output logic [31:0] f, output logic [4:0] t, output int lat);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    f = out_float;
    t = out_type;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Full directed/random step: convert, compare with constant and model.
  task automatic run_case(input string tag, input logic [31:0] d, input logic s,
                          input logic [31:0] want_f, input logic use_want);
    logic [31:0] f, mf;
    logic [4:0]  t, mt;
    int          lat, mlat;
    ref_conv(d, s, mf, mt, mlat);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    conv(d, s, f, t, lat);
    chk({tag, "_float"}, f, use_want ? want_f : mf);
    chk({tag, "_type"}, {27'd0, t}, {27'd0, mt});
    chk({tag, "_lat"}, lat, mlat);
    handshake();
    chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hold"}, out_float, use_want ? want_f : mf);
  endtask

  logic [31:0] f;
  logic [4:0]  t;
  int          lat;
  logic [31:0] rd;
  logic        rs;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_float", out_float, 32'd0);
    chk("rst_out_type", {27'd0, out_type}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed cases with the expected words written out.
    run_case("one",       32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b1);
    chk("one_lat_abs", FAST ? 12 : 33, FAST ? 12 : 33);
    run_case("m1_s",      32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b1);
    run_case("max_u",     32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1);
    run_case("min_s",     32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b1);
    run_case("msb_u",     32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b1);
    run_case("tie_even",  32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
    run_case("tie_odd",   32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1);
    run_case("tie_even2", 32'h0100_0005, 1'b0, 32'h4B80_0002, 1'b1);

    // Absolute latency for in_data=1, independent of the model.
    conv(32'h0000_0001, 1'b0, f, t, lat);
    if (FAST) chk("lat_one_fast", lat, 12);
    else      chk("lat_one_plain", lat, 33);
    handshake();

    // Zero operand then backpressure with stray in_valid pulses.
    conv(32'd0, 1'b1, f, t, lat);
    chk("zero_float", f, 32'h0000_0000);
    chk("zero_type", {27'd0, t}, 32'h0000_0001);
    chk("zero_lat", lat, 0);
    for (int i = 0; i < 5; i++) begin
      in_data   = 32'h0001_2345;
      in_signed = 1'b0;
      in_valid  = (i % 2 == 0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_float", out_float, 32'd0);
      chk("bp_type", {27'd0, out_type}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_no_accept", {31'd0, out_valid}, 32'd0);
    tick();
    chk("bp_still_idle", {31'd0, in_ready}, 32'd1);

    // Leave a nonzero result on out_float, then reset three cycles into NORM.
    run_case("pre_rst", 32'h0000_0003, 1'b0, 32'h4040_0000, 1'b1);
    in_data   = 32'h0000_0001;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_float", out_float, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_case("seven", 32'h0000_0007, 1'b0, 32'h40E0_0000, 1'b1);

    // Random operands with varied leading-zero counts against the model.
    for (int i = 0; i < 40; i++) begin
      rd = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      if (i % 7 == 0) rd = ~rd;
      run_case("rand", rd, rs, 32'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Multi-cycle converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision word.
- Rounding is round-to-nearest-even.
- Also emits the 5-bit one-hot float class code used by the team's float classifier: 00001 zero, 00010 normal, 00100 subnormal, 01000 infinity, 10000 NaN.
- Sits between the integer datapath and float consumers.
- Valid/ready handshake on both sides; one conversion in flight.

Parameters:
- BIAS, 127, exponent bias.
- INT_W, 32, integer input width. Fixed at 32; not for override.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_signed valid
- in_ready  output  1  converter idle, can accept
- in_data  input  32  integer operand
- in_signed  input  1  1: in_data is two's complement; 0: unsigned
- out_valid  output  1  out_float/out_type valid
- out_ready  input  1  consumer accepts result
- out_float  output  32  {sign, exp[7:0], mant[22:0]}
- out_type  output  5  one-hot class of out_float (only 00001 or 00010 can occur)

Behaviour:
- Reset (async, clk-independent): state=IDLE, in_ready=1, out_valid=0, out_float=0, out_type=0, internal mag/exp/sign=0. Reset mid-conversion abandons the operation; no partial result is ever presented.
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE), combinational from state. in_valid outside IDLE is ignored.
- IDLE, on in_valid&in_ready:
  - sign = in_signed & in_data[31].
  - mag = sign ? (~in_data+1) : in_data, 32-bit unsigned. Signed 0x80000000 gives mag 0x80000000.
  - exp = BIAS+31 = 158, 9-bit internal.
  - If mag==0: out_float=0x00000000, out_type=00001, go DONE. Sign is forced 0, so no -0 result.
  - Otherwise go NORM.
- NORM, once per cycle:
  - If mag[31]: go ROUND.
  - Else: mag<<=1, exp-=1.
- ROUND, one cycle:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up iff guard & (sticky | mant[0]).
  - If mant is all-ones and rounds up: mant=0, exp+=1.
  - Register out_float = {sign, exp[7:0], mant} and out_type = 00010. Go DONE.
- DONE:
  - out_valid=1. out_float/out_type held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, go IDLE.
  - out_float/out_type retain their last value after the handshake, until the next result.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - Zero input: 1 cycle.
  - Nonzero input: lz+2 cycles, where lz = leading zeros of mag (0..31).
- Throughput: the earliest next accept is the cycle after the out handshake (the IDLE cycle). There is no same-cycle output/input overlap.
- Exponent never underflows (minimum 127) and never overflows (maximum 159). Infinity, NaN and subnormal are unreachable.

Optional Feature:
- Macro: INT_TO_FLOAT_FAST_NORM_EN.
- Defined: in NORM, if mag[31:24]==0 then mag<<=8, exp-=8; otherwise use the 1-bit rule. Nonzero latency becomes floor(lz/8) + (lz mod 8) + 2.
- Undefined: 1-bit shift only, as above.
- Results are bit-identical either way; only latency differs.

Test Plan:
- in_data=1, in_signed=0 -> out_float=0x3F800000, out_type=00010.
  - Plain build: out_valid 33 cycles after accept.
  - FAST_NORM_EN build: out_valid 12 cycles after accept.
- in_data=0xFFFFFFFF:
  - in_signed=1 -> 0xBF800000.
  - in_signed=0 -> 0x4F800000 (mantissa-overflow rounding, exp 158->159).
- in_data=0x80000000:
  - in_signed=1 -> 0xCF000000.
  - in_signed=0 -> 0x4F000000.
  - Latency 2 in both cases.
- Rounding checks:
  - 0x01000001 -> 0x4B800000 (tie, even, no round-up).
  - 0x01000003 -> 0x4B800002 (tie, odd, round-up).
  - 0x01000005 -> 0x4B800002 (tie, even, no round-up).
- Zero and backpressure:
  - in_data=0 -> 0x00000000, out_type=00001, out_valid one cycle after accept.
  - Hold out_ready=0 for 5 cycles: out_valid, out_float and in_ready=0 stable throughout. in_valid pulses during this time are not accepted.
- Reset mid-operation: assert reset 3 cycles into NORM for in_data=1.
  - Immediately, without a clock edge: out_valid=0, in_ready=1, out_float=0.
  - After release, convert 7 -> 0x40E00000.
